rojo_port_responder: RTL and testbench

//  Port-mapped peripheral on the RojoBlaze I/O bus; the responder to the core's OUTPUT/INPUT instructions and interrupt line.

---
 rtl/kcpsmx3_inc.sv | 38 +++
 rtl/rojo_sync_fifo.sv | 66 ++++++
 rtl/rojo_port_responder.sv | 173 +++++++++++++++++
 tb/tb_rojo_port_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/kcpsmx3_inc.sv
// Shared RojoBlaze I/O bus definitions: bus widths, register offsets, pending bits, IRQ states.
package kcpsmx3_inc;

  localparam int unsigned PORT_WIDTH = 8;
  localparam int unsigned PORT_DEPTH = 8;
  localparam int unsigned NUM_REGS   = 5;
  localparam int unsigned PEND_W     = 4;

  localparam logic [PORT_DEPTH-1:0] REG_DATA = PORT_DEPTH'(0);
  localparam logic [PORT_DEPTH-1:0] REG_STAT = PORT_DEPTH'(1);
  localparam logic [PORT_DEPTH-1:0] REG_MASK = PORT_DEPTH'(2);
  localparam logic [PORT_DEPTH-1:0] REG_PEND = PORT_DEPTH'(3);
  localparam logic [PORT_DEPTH-1:0] REG_SCR  = PORT_DEPTH'(4);

  localparam int unsigned PEND_RX_AVAIL = 0;
  localparam int unsigned PEND_TX_DONE  = 1;
  localparam int unsigned PEND_RX_OVF   = 2;
  localparam int unsigned PEND_TX_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_CLR = 2'd2
  } irq_state_t;

  typedef struct packed {
    logic rx_full;
    logic rx_empty;
    logic tx_full;
    logic tx_empty;
  } stat_t;

  // Zero-extend a 4-bit register field onto the read bus.
  function automatic logic [PORT_WIDTH-1:0] zext4(input logic [PEND_W-1:0] v);
    return {{(PORT_WIDTH - PEND_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/rojo_sync_fifo.sv
// Single-clock FIFO with registered flags; head shows the oldest entry.
module rojo_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             can_push,
  output logic             empty_nxt_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle frees a slot for a push into a full FIFO.
  always_comb begin
    do_pop    = pop & ~empty;
    do_push   = push & (~full | do_pop);
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
    empty_nxt_c = (count_nxt == CW'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      can_push <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[AW'(i)] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      full     <= (count_nxt == CW'(DEPTH));
      empty    <= empty_nxt_c;
      can_push <= (count_nxt != CW'(DEPTH));
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/rojo_port_responder.sv
// RojoBlaze port-mapped responder: register decode, TX/RX byte FIFOs, sticky events and IRQ handshake.
module rojo_port_responder
  import kcpsmx3_inc::*;
#(
  parameter logic [PORT_DEPTH-1:0] BASE_ADDR  = 8'h00,
  parameter int unsigned           FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PORT_DEPTH-1:0] port_id,
  input  logic                  write_strobe,
  input  logic                  read_strobe,
  input  logic [PORT_WIDTH-1:0] out_port,
  output logic [PORT_WIDTH-1:0] in_port,
  output logic                  interrupt,
  input  logic                  interrupt_ack,
  output logic [PORT_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [PORT_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready
);

  logic [1:0]            rst_sync;
  logic                  rst_n;
  logic [PORT_DEPTH-1:0] offset_c;
  logic                  wr_c;
  logic                  rd_c;
  logic                  tx_wr_c;
  logic                  tx_push_c;
  logic                  tx_pop_c;
  logic                  rx_push_c;
  logic                  rx_pop_c;
  logic                  tx_full;
  logic                  tx_empty;
  logic                  tx_can_push;
  logic                  tx_empty_nxt_c;
  logic                  rx_full;
  logic                  rx_empty;
  logic                  rx_empty_nxt_c;
  logic [PORT_WIDTH-1:0] rx_head;
  logic [PEND_W-1:0]     events_c;
  logic [PEND_W-1:0]     pend;
  logic [PEND_W-1:0]     pend_nxt_c;
  logic [PEND_W-1:0]     mask;
  logic [PORT_WIDTH-1:0] scr;
  logic [PORT_WIDTH-1:0] rd_mux_c;
  logic                  irq_any_c;
  logic                  irq_c;
  stat_t                 stat_c;
  irq_state_t            state;
  irq_state_t            state_nxt;

  // Assert asynchronously, release two clocks after reset rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Address decode and FIFO handshakes.
  always_comb begin
    offset_c  = port_id - BASE_ADDR;
    wr_c      = write_strobe & (offset_c < PORT_DEPTH'(NUM_REGS));
    rd_c      = read_strobe & (offset_c < PORT_DEPTH'(NUM_REGS));
    tx_pop_c  = ~tx_empty & tx_ready;
    tx_wr_c   = wr_c & (offset_c == REG_DATA);
    tx_push_c = tx_wr_c & (tx_can_push | tx_pop_c);
    rx_push_c = rx_valid & rx_ready;
    rx_pop_c  = rd_c & (offset_c == REG_DATA) & ~rx_empty;
  end

  rojo_sync_fifo #(.WIDTH(PORT_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (tx_push_c),
    .pop         (tx_pop_c),
    .din         (out_port),
    .head        (tx_data),
    .full        (tx_full),
    .empty       (tx_empty),
    .can_push    (tx_can_push),
    .empty_nxt_c (tx_empty_nxt_c)
  );

  rojo_sync_fifo #(.WIDTH(PORT_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (rx_push_c),
    .pop         (rx_pop_c),
    .din         (rx_data),
    .head        (rx_head),
    .full        (rx_full),
    .empty       (rx_empty),
    .can_push    (rx_ready),
    .empty_nxt_c (rx_empty_nxt_c)
  );

  assign tx_valid = ~tx_empty;

  // Sticky events; a new event beats a same-cycle W1C of its bit.
  always_comb begin
    events_c                = '0;
    events_c[PEND_RX_AVAIL] = rx_empty & ~rx_empty_nxt_c;
    events_c[PEND_TX_DONE]  = ~tx_empty & tx_empty_nxt_c;
    events_c[PEND_RX_OVF]   = rx_valid & rx_full;
    events_c[PEND_TX_OVF]   = tx_wr_c & ~tx_push_c;
    pend_nxt_c              = pend;
    if (wr_c && (offset_c == REG_PEND)) pend_nxt_c = pend & ~out_port[PEND_W-1:0];
    pend_nxt_c = pend_nxt_c | events_c;
  end

  always_comb begin
    stat_c   = '{rx_full: rx_full, rx_empty: rx_empty, tx_full: tx_full, tx_empty: tx_empty};
    rd_mux_c = '0;
    case (offset_c)
      REG_DATA: rd_mux_c = rx_empty ? '0 : rx_head;
      REG_STAT: rd_mux_c = zext4(stat_c);
      REG_MASK: rd_mux_c = zext4(mask);
      REG_PEND: rd_mux_c = zext4(pend);
      REG_SCR:  rd_mux_c = scr;
      default:  rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask    <= '0;
      scr     <= '0;
      pend    <= '0;
      in_port <= '0;
    end else begin
      if (wr_c && (offset_c == REG_MASK)) mask <= out_port[PEND_W-1:0];
      if (wr_c && (offset_c == REG_SCR))  scr  <= out_port;
      pend    <= pend_nxt_c;
      in_port <= rd_mux_c;
    end
  end

  // IRQ FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // IRQ FSM: next state; after an ack, stay quiet until the cause is cleared or masked.
  always_comb begin
    irq_any_c = |(pend & mask);
    state_nxt = state;
    case (state)
      IDLE:     if (irq_any_c) state_nxt = ASSERT;
      ASSERT: begin
        if (interrupt_ack)   state_nxt = WAIT_CLR;
        else if (!irq_any_c) state_nxt = IDLE;
      end
      WAIT_CLR: if (!irq_any_c) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // IRQ FSM: output decode, registered onto the interrupt pin.
  always_comb begin
    irq_c = 1'b0;
    if (state_nxt == ASSERT) irq_c = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) interrupt <= 1'b0;
    else        interrupt <= irq_c;
  end

endmodule

// File: tb/tb_rojo_port_responder.sv
// Directed bench for rojo_port_responder at BASE_ADDR 0x40.
module tb_rojo_port_responder;

  localparam logic [7:0] BASE   = 8'h40;
  localparam logic [7:0] A_DATA = BASE + 8'd0;
  localparam logic [7:0] A_STAT = BASE + 8'd1;
  localparam logic [7:0] A_MASK = BASE + 8'd2;
  localparam logic [7:0] A_PEND = BASE + 8'd3;
  localparam logic [7:0] A_SCR  = BASE + 8'd4;
  localparam logic [7:0] A_NONE = BASE + 8'd7;

  logic       clk;
  logic       reset;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  int checks = 0;
  int errors = 0;
  logic [7:0] rd_val;

  rojo_port_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .out_port      (out_port),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    port_id      = addr;
    out_port     = data;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  // port_id settles one cycle, then the strobe cycle captures in_port.
  task automatic rd(input logic [7:0] addr, output logic [7:0] data);
    port_id = addr;
    tick();
    read_strobe = 1'b1;
    tick();
    data        = in_port;
    read_strobe = 1'b0;
  endtask

  initial begin
    reset = 1'b0; port_id = '0; write_strobe = 1'b0; read_strobe = 1'b0;
    out_port = '0; interrupt_ack = 1'b0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    tick(); tick(); tick();
    chk8("rst_in_port", in_port, 8'h00);
    chk1("rst_interrupt", interrupt, 1'b0);
    chk1("rst_tx_valid", tx_valid, 1'b0);
    chk8("rst_tx_data", tx_data, 8'h00);
    chk1("rst_rx_ready", rx_ready, 1'b0);
    reset = 1'b1;
    tick(); tick(); tick(); tick();
    chk1("post_rst_rx_ready", rx_ready, 1'b1);
    rd(A_STAT, rd_val); chk8("post_rst_stat", rd_val, 8'h05);

    // Single TX byte
    tx_ready = 1'b1;
    wr(A_DATA, 8'hA5);
    chk1("tx1_valid", tx_valid, 1'b1);
    chk8("tx1_data", tx_data, 8'hA5);
    rd(A_PEND, rd_val); chk8("tx1_pend", rd_val, 8'h02);
    chk1("tx1_drained", tx_valid, 1'b0);
    wr(A_PEND, 8'h0F);

    // RX bytes, interrupt handshake
    rx_valid = 1'b1; rx_data = 8'h11; tick();
    rx_data = 8'h22; tick();
    rx_valid = 1'b0;
    chk1("irq_masked_off", interrupt, 1'b0);
    wr(A_MASK, 8'h01);
    tick();
    chk1("irq_raise", interrupt, 1'b1);
    interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
    chk1("irq_after_ack", interrupt, 1'b0);
    tick(); tick();
    chk1("irq_stays_low", interrupt, 1'b0);
    rd(A_DATA, rd_val); chk8("rx_pop0", rd_val, 8'h11);
    rd(A_DATA, rd_val); chk8("rx_pop1", rd_val, 8'h22);
    chk1("irq_low_wait_clr", interrupt, 1'b0);
    wr(A_PEND, 8'h01);
    rd(A_PEND, rd_val); chk8("pend_w1c", rd_val, 8'h00);
    rx_valid = 1'b1; rx_data = 8'h33; tick(); rx_valid = 1'b0;
    tick();
    chk1("irq_reraise_from_idle", interrupt, 1'b1);
    wr(A_MASK, 8'h00);
    tick();
    chk1("irq_mask_clear_drop", interrupt, 1'b0);
    rd(A_DATA, rd_val); chk8("rx_pop2", rd_val, 8'h33);
    wr(A_PEND, 8'h0F);

    // TX overflow with a stalled sink
    tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) wr(A_DATA, 8'(i));
    rd(A_STAT, rd_val); chk8("tx_full_stat", rd_val, 8'h06);
    wr(A_DATA, 8'h05);
    rd(A_PEND, rd_val); chk8("tx_ovf_pend", rd_val, 8'h08);
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk1("tx_drain_valid", tx_valid, 1'b1);
      chk8("tx_drain_data", tx_data, 8'(i));
      tick();
    end
    chk1("tx_drain_empty", tx_valid, 1'b0);
    wr(A_PEND, 8'h0F);

    // RX overflow and empty read
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'hC0 + 8'(i);
      tick();
    end
    chk1("rx_full_ready", rx_ready, 1'b0);
    rx_data = 8'hC4; tick();
    rx_valid = 1'b0;
    rd(A_PEND, rd_val); chk8("rx_ovf_pend", rd_val, 8'h05);
    for (int i = 0; i < 4; i++) begin
      rd(A_DATA, rd_val); chk8("rx_drain", rd_val, 8'hC0 + 8'(i));
    end
    chk1("rx_ready_again", rx_ready, 1'b1);
    wr(A_PEND, 8'h0F);
    rd(A_DATA, rd_val); chk8("rx_empty_read", rd_val, 8'h00);
    rd(A_PEND, rd_val); chk8("rx_empty_no_pend", rd_val, 8'h00);

    // Scratch, read-only status, masking width, unmapped port
    wr(A_SCR, 8'h5A);
    rd(A_SCR, rd_val); chk8("scr_rw", rd_val, 8'h5A);
    wr(A_STAT, 8'hFF);
    rd(A_STAT, rd_val); chk8("stat_ro", rd_val, 8'h05);
    wr(A_MASK, 8'hFF);
    rd(A_MASK, rd_val); chk8("mask_width", rd_val, 8'h0F);
    wr(A_MASK, 8'h00);
    wr(A_NONE, 8'h77);
    rd(A_NONE, rd_val); chk8("unmapped_read", rd_val, 8'h00);
    rd(A_SCR, rd_val); chk8("unmapped_write_no_effect", rd_val, 8'h5A);

    // Reset while interrupting with bytes queued in TX
    tx_ready = 1'b0;
    wr(A_DATA, 8'hD1);
    wr(A_DATA, 8'hD2);
    rx_valid = 1'b1; rx_data = 8'hE0; tick(); rx_valid = 1'b0;
    wr(A_MASK, 8'h01);
    tick();
    chk1("pre_rst_irq", interrupt, 1'b1);
    chk1("pre_rst_tx_valid", tx_valid, 1'b1);
    reset = 1'b0;
    #1;
    chk1("mid_rst_irq", interrupt, 1'b0);
    chk1("mid_rst_tx_valid", tx_valid, 1'b0);
    chk1("mid_rst_rx_ready", rx_ready, 1'b0);
    chk8("mid_rst_in_port", in_port, 8'h00);
    tick(); tick();
    reset = 1'b1;
    tick(); tick(); tick(); tick();
    rd(A_STAT, rd_val); chk8("rst_release_stat", rd_val, 8'h05);
    rd(A_PEND, rd_val); chk8("rst_release_pend", rd_val, 8'h00);
    rd(A_SCR, rd_val); chk8("rst_release_scr", rd_val, 8'h00);
    chk1("rst_release_irq", interrupt, 1'b0);
    chk1("rst_release_tx_valid", tx_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
